// File: rtl/stitch_wr_packer.sv
`default_nettype none
// ============================================================================
// Module   : stitch_wr_packer
// Packs stitched RGB565 pixels into 128-bit words and writes them as bursts
// into a ping-pong frame buffer.
// Revision : 1.0
// ============================================================================
module stitch_wr_packer #(
    parameter int unsigned LINE_PIX    = 980,
    parameter int unsigned BURST_WORDS = 16,
    parameter logic [23:0] BUF_STRIDE  = 24'h040000
) (
    input  logic         sys_rst_n,
    input  logic         cmos0_pclk,
    input  logic         pixel_vsync,
    input  logic         pixel_href,
    input  logic [15:0]  pixel_data,
    output logic         wr_req,
    output logic [23:0]  wr_addr,
    output logic [5:0]   wr_len,
    input  logic         wr_ack,
    output logic [127:0] wr_data,
    output logic         wr_valid,
    output logic         wr_last,
    input  logic         wr_ready,
    output logic         frame_done,
    output logic         buf_sel,
    output logic         ovf_err,
    output logic         seq_err
);

    localparam int unsigned FIFO_DEPTH = 64;
    localparam logic [6:0]  C_BURST7   = 7'(BURST_WORDS);
    localparam logic [5:0]  C_BURST6   = 6'(BURST_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_SWAP = 2'd3;

    generate
        if (LINE_PIX < 1 || BURST_WORDS < 1 || BURST_WORDS > 32) begin : g_param_check
            $error("stitch_wr_packer: illegal LINE_PIX or BURST_WORDS");
        end
    endgenerate

    // Reset asserts immediately, deasserts two clocks after sys_rst_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Pixel packer
    logic [2:0]   r_slot;
    logic [127:0] r_acc;
    logic [127:0] r_push_word;
    logic         r_push_vld;
    logic         r_href_d;

    always_ff @(posedge cmos0_pclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_slot      <= 3'd0;
            r_acc       <= '0;
            r_push_word <= '0;
            r_push_vld  <= 1'b0;
            r_href_d    <= 1'b0;
        end else begin
            r_href_d   <= pixel_href;
            r_push_vld <= 1'b0;
            if (pixel_href) begin
                if (r_slot == 3'd7) begin
                    r_push_word <= {pixel_data, r_acc[111:0]};
                    r_push_vld  <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc[{r_slot, 4'b0000} +: 16] <= pixel_data;
                end
                r_slot <= r_slot + 3'd1;
            end else if (r_href_d && r_slot != 3'd0) begin
                // Unused slots are already zero, so the partial word is ready as-is.
                r_push_word <= r_acc;
                r_push_vld  <= 1'b1;
                r_acc       <= '0;
                r_slot      <= 3'd0;
            end
        end
    end

    // First-word-fall-through FIFO
    logic [127:0] r_mem [FIFO_DEPTH];
    logic [5:0]   r_wr_ptr;
    logic [5:0]   r_rd_ptr;
    logic [6:0]   r_count;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    assign w_full = (r_count == 7'(FIFO_DEPTH));
    assign w_push = r_push_vld && !w_full;
    assign w_pop  = wr_valid && wr_ready;

    always_ff @(posedge cmos0_pclk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_push_word;
    end

    always_ff @(posedge cmos0_pclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= 6'd0;
            r_rd_ptr <= 6'd0;
            r_count  <= 7'd0;
            ovf_err  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 6'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 6'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 7'd1;
                2'b01:   r_count <= r_count - 7'd1;
                default: r_count <= r_count;
            endcase
            if (r_push_vld && w_full) ovf_err <= 1'b1;
        end
    end

    // Burst write sequencer
    logic [1:0]  r_state;
    logic [5:0]  r_len;
    logic [5:0]  r_remain;
    logic [23:0] r_addr;
    logic        r_buf_sel;
    logic        r_flush_pend;
    logic        r_vs_d;
    logic        w_vs_rise;

    assign w_vs_rise = pixel_vsync && !r_vs_d;

    always_ff @(posedge cmos0_pclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= 6'd0;
            r_remain     <= 6'd0;
            r_addr       <= 24'd0;
            r_buf_sel    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_vs_d       <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            r_vs_d <= pixel_vsync;
            case (r_state)
                ST_IDLE: begin
                    if (r_count >= C_BURST7) begin
                        r_len   <= C_BURST6;
                        r_state <= ST_REQ;
                    end else if (r_flush_pend) begin
                        if (r_count != 7'd0) begin
                            r_len   <= r_count[5:0];
                            r_state <= ST_REQ;
                        end else begin
                            r_state <= ST_SWAP;
                        end
                    end
                end
                ST_REQ: begin
                    if (wr_ack) begin
                        r_remain <= r_len;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        r_remain <= r_remain - 6'd1;
                        if (r_remain == 6'd1) begin
                            r_addr  <= r_addr + {18'd0, r_len};
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_buf_sel    <= ~r_buf_sel;
                    r_addr       <= r_buf_sel ? 24'd0 : BUF_STRIDE;
                    r_flush_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
            // A new frame while the previous flush is outstanding is only flagged.
            if (w_vs_rise) begin
                if (r_flush_pend) seq_err      <= 1'b1;
                else              r_flush_pend <= 1'b1;
            end
            if (pixel_href && r_flush_pend) seq_err <= 1'b1;
        end
    end

    assign wr_req     = (r_state == ST_REQ);
    assign wr_addr    = r_addr;
    assign wr_len     = r_len;
    assign wr_valid   = (r_state == ST_DATA);
    assign wr_last    = wr_valid && (r_remain == 6'd1);
    assign wr_data    = (r_count != 7'd0) ? r_mem[r_rd_ptr] : 128'd0;
    assign frame_done = (r_state == ST_SWAP);
    assign buf_sel    = r_buf_sel;

endmodule
`default_nettype wire

// File: tb/tb_stitch_wr_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_stitch_wr_packer
// Directed self-checking bench for stitch_wr_packer (burst 16 and burst 2).
// Revision : 1.0
// ============================================================================
module tb_stitch_wr_packer;

    logic        cmos0_pclk  = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        pixel_vsync = 1'b0;
    logic        pixel_href  = 1'b0;
    logic [15:0] pixel_data  = 16'd0;
    logic        wr_ack      = 1'b0;
    logic        wr_ready    = 1'b0;

    logic         d16_wr_req, d16_wr_valid, d16_wr_last, d16_frame_done, d16_buf_sel, d16_ovf_err, d16_seq_err;
    logic [23:0]  d16_wr_addr;
    logic [5:0]   d16_wr_len;
    logic [127:0] d16_wr_data;
    logic         d2_wr_req, d2_wr_valid, d2_wr_last, d2_frame_done, d2_buf_sel, d2_ovf_err, d2_seq_err;
    logic [23:0]  d2_wr_addr;
    logic [5:0]   d2_wr_len;
    logic [127:0] d2_wr_data;

    int checks = 0;
    int errors = 0;

    logic [127:0] q16_data[$];
    logic         q16_last[$];
    logic [23:0]  r16_addr[$];
    logic [5:0]   r16_len[$];
    int           req16_cnt = 0;
    int           fd16_cnt  = 0;
    logic [127:0] q2_data[$];
    logic         q2_last[$];
    logic [23:0]  r2_addr[$];
    logic [5:0]   r2_len[$];

    always #5 cmos0_pclk = ~cmos0_pclk;

    stitch_wr_packer u_dut16 (
        .sys_rst_n(sys_rst_n), .cmos0_pclk(cmos0_pclk),
        .pixel_vsync(pixel_vsync), .pixel_href(pixel_href), .pixel_data(pixel_data),
        .wr_req(d16_wr_req), .wr_addr(d16_wr_addr), .wr_len(d16_wr_len), .wr_ack(wr_ack),
        .wr_data(d16_wr_data), .wr_valid(d16_wr_valid), .wr_last(d16_wr_last), .wr_ready(wr_ready),
        .frame_done(d16_frame_done), .buf_sel(d16_buf_sel), .ovf_err(d16_ovf_err), .seq_err(d16_seq_err)
    );

    stitch_wr_packer #(.BURST_WORDS(2)) u_dut2 (
        .sys_rst_n(sys_rst_n), .cmos0_pclk(cmos0_pclk),
        .pixel_vsync(pixel_vsync), .pixel_href(pixel_href), .pixel_data(pixel_data),
        .wr_req(d2_wr_req), .wr_addr(d2_wr_addr), .wr_len(d2_wr_len), .wr_ack(wr_ack),
        .wr_data(d2_wr_data), .wr_valid(d2_wr_valid), .wr_last(d2_wr_last), .wr_ready(wr_ready),
        .frame_done(d2_frame_done), .buf_sel(d2_buf_sel), .ovf_err(d2_ovf_err), .seq_err(d2_seq_err)
    );

    // Record every accepted word and every accepted request
    always @(posedge cmos0_pclk) begin
        if (d16_wr_valid && wr_ready) begin
            q16_data.push_back(d16_wr_data);
            q16_last.push_back(d16_wr_last);
        end
        if (d16_wr_req && wr_ack) begin
            r16_addr.push_back(d16_wr_addr);
            r16_len.push_back(d16_wr_len);
        end
        if (d16_wr_req)     req16_cnt <= req16_cnt + 1;
        if (d16_frame_done) fd16_cnt  <= fd16_cnt + 1;
        if (d2_wr_valid && wr_ready) begin
            q2_data.push_back(d2_wr_data);
            q2_last.push_back(d2_wr_last);
        end
        if (d2_wr_req && wr_ack) begin
            r2_addr.push_back(d2_wr_addr);
            r2_len.push_back(d2_wr_len);
        end
    end

    function automatic logic [127:0] mk_word(input int base);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(base + j);
        return w;
    endfunction

    task automatic do_reset();
        sys_rst_n = 1'b0; pixel_href = 1'b0; pixel_vsync = 1'b0; pixel_data = 16'd0;
        wr_ack = 1'b0; wr_ready = 1'b0;
        repeat (3) @(negedge cmos0_pclk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge cmos0_pclk);
    endtask

    task automatic send_pixels(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            @(negedge cmos0_pclk);
            pixel_href = 1'b1;
            pixel_data = 16'(start + i);
        end
        @(negedge cmos0_pclk);
        pixel_href = 1'b0;
        pixel_data = 16'd0;
    endtask

    task automatic wait_words16(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && q16_data.size() < target; i++) @(negedge cmos0_pclk);
    endtask

    task automatic wait_frame16(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && fd16_cnt < target; i++) @(negedge cmos0_pclk);
    endtask

    task automatic test_reset();
        logic [35:0] o16, o2;
        sys_rst_n = 1'b0; wr_ack = 1'b1; wr_ready = 1'b1;
        @(negedge cmos0_pclk);
        o16 = {d16_wr_req, d16_wr_addr, d16_wr_len, d16_wr_valid, d16_wr_last, d16_frame_done, d16_buf_sel, d16_ovf_err, d16_seq_err};
        o2  = {d2_wr_req, d2_wr_addr, d2_wr_len, d2_wr_valid, d2_wr_last, d2_frame_done, d2_buf_sel, d2_ovf_err, d2_seq_err};
        checks++; if (o16 !== 36'd0) begin errors++; $display("FAIL reset_outs16: got %h expected 0", o16); end
        checks++; if (d16_wr_data !== 128'd0) begin errors++; $display("FAIL reset_data16: got %h expected 0", d16_wr_data); end
        checks++; if (o2 !== 36'd0) begin errors++; $display("FAIL reset_outs2: got %h expected 0", o2); end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge cmos0_pclk);
        o16 = {d16_wr_req, d16_wr_addr, d16_wr_len, d16_wr_valid, d16_wr_last, d16_frame_done, d16_buf_sel, d16_ovf_err, d16_seq_err};
        checks++; if (o16 !== 36'd0) begin errors++; $display("FAIL idle_after_reset: got %h expected 0", o16); end
    endtask

    task automatic test_reset_sync();
        int b;
        sys_rst_n = 1'b0; pixel_href = 1'b0; pixel_vsync = 1'b0; wr_ack = 1'b1; wr_ready = 1'b1;
        repeat (3) @(negedge cmos0_pclk);
        b = q16_data.size();
        sys_rst_n  = 1'b1;
        pixel_href = 1'b1;
        pixel_data = 16'd1;
        for (int i = 2; i <= 10; i++) begin
            @(negedge cmos0_pclk);
            pixel_data = 16'(i);
        end
        @(negedge cmos0_pclk);
        pixel_href = 1'b0;
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        wait_words16(b + 1, 30);
        repeat (5) @(negedge cmos0_pclk);
        pixel_vsync = 1'b0;
        checks++; if (q16_data.size() - b !== 1) begin errors++; $display("FAIL sync_word_count: got %0d expected 1", q16_data.size() - b); end
        checks++; if (q16_data[b] !== mk_word(3)) begin errors++; $display("FAIL sync_first_pixel: got %h expected %h", q16_data[b], mk_word(3)); end
    endtask

    task automatic test_basic_pack();
        int b, br;
        do_reset();
        wr_ack = 1'b1; wr_ready = 1'b1;
        b = q2_data.size(); br = r2_addr.size();
        send_pixels(16, 1);
        for (int i = 0; i < 30 && q2_data.size() < b + 2; i++) @(negedge cmos0_pclk);
        repeat (3) @(negedge cmos0_pclk);
        checks++; if (r2_addr.size() - br !== 1) begin errors++; $display("FAIL b2_req_count: got %0d expected 1", r2_addr.size() - br); end
        checks++; if (r2_addr[br] !== 24'd0) begin errors++; $display("FAIL b2_req_addr: got %h expected 0", r2_addr[br]); end
        checks++; if (r2_len[br] !== 6'd2) begin errors++; $display("FAIL b2_req_len: got %0d expected 2", r2_len[br]); end
        checks++; if (q2_data.size() - b !== 2) begin errors++; $display("FAIL b2_word_count: got %0d expected 2", q2_data.size() - b); end
        checks++; if (q2_data[b] !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("FAIL b2_word0: got %h", q2_data[b]); end
        checks++; if (q2_data[b+1] !== 128'h0010_000f_000e_000d_000c_000b_000a_0009) begin errors++; $display("FAIL b2_word1: got %h", q2_data[b+1]); end
        checks++; if ({q2_last[b], q2_last[b+1]} !== 2'b01) begin errors++; $display("FAIL b2_last: got %b expected 01", {q2_last[b], q2_last[b+1]}); end
    endtask

    task automatic test_line_pad();
        int b, fd0;
        logic [127:0] exp_tail;
        do_reset();
        wr_ack = 1'b1; wr_ready = 1'b1;
        b = q16_data.size(); fd0 = fd16_cnt;
        send_pixels(980, 1);
        repeat (40) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        wait_frame16(fd0 + 1, 100);
        repeat (5) @(negedge cmos0_pclk);
        pixel_vsync = 1'b0;
        exp_tail = {64'd0, 16'd980, 16'd979, 16'd978, 16'd977};
        checks++; if (q16_data.size() - b !== 123) begin errors++; $display("FAIL line_word_count: got %0d expected 123", q16_data.size() - b); end
        checks++; if (q16_data[b] !== mk_word(1)) begin errors++; $display("FAIL line_word0: got %h expected %h", q16_data[b], mk_word(1)); end
        checks++; if (q16_data[b+121] !== mk_word(969)) begin errors++; $display("FAIL line_word121: got %h expected %h", q16_data[b+121], mk_word(969)); end
        checks++; if (q16_data[b+122] !== exp_tail) begin errors++; $display("FAIL line_padded_tail: got %h expected %h", q16_data[b+122], exp_tail); end
        checks++; if (r16_len[r16_len.size()-1] !== 6'd11) begin errors++; $display("FAIL line_flush_len: got %0d expected 11", r16_len[r16_len.size()-1]); end
    endtask

    task automatic test_ready_toggle();
        int b, mism, lastbad;
        bit seen, drop;
        do_reset();
        wr_ack = 1'b1; wr_ready = 1'b0;
        b = q16_data.size();
        send_pixels(128, 16'h1000);
        seen = 0; drop = 0;
        for (int c = 0; c < 100 && q16_data.size() < b + 16; c++) begin
            @(negedge cmos0_pclk);
            if (q16_data.size() < b + 16) begin
                if (d16_wr_valid) seen = 1;
                else if (seen)    drop = 1;
            end
            wr_ready = ~wr_ready;
        end
        wr_ready = 1'b1;
        repeat (5) @(negedge cmos0_pclk);
        mism = 0; lastbad = 0;
        for (int k = 0; k < 16; k++) begin
            if (q16_data[b+k] !== mk_word(16'h1000 + 8*k)) mism++;
            if (q16_last[b+k] !== (k == 15)) lastbad++;
        end
        checks++; if (q16_data.size() - b !== 16) begin errors++; $display("FAIL toggle_count: got %0d expected 16", q16_data.size() - b); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL toggle_order: got %0d bad words expected 0", mism); end
        checks++; if (lastbad !== 0) begin errors++; $display("FAIL toggle_last: got %0d bad flags expected 0", lastbad); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL toggle_valid_drop: got %0d expected 0", drop); end
    endtask

    task automatic test_flush_swap();
        int b, br, fd0;
        do_reset();
        wr_ack = 1'b1; wr_ready = 1'b1;
        b = q16_data.size(); br = r16_addr.size(); fd0 = fd16_cnt;
        send_pixels(40, 16'h0200);
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        wait_frame16(fd0 + 1, 40);
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b0;
        checks++; if (r16_len[br] !== 6'd5) begin errors++; $display("FAIL flush_len: got %0d expected 5", r16_len[br]); end
        checks++; if (r16_addr[br] !== 24'd0) begin errors++; $display("FAIL flush_addr: got %h expected 0", r16_addr[br]); end
        checks++; if (q16_data[b+4] !== mk_word(16'h0220)) begin errors++; $display("FAIL flush_word4: got %h expected %h", q16_data[b+4], mk_word(16'h0220)); end
        checks++; if (fd16_cnt - fd0 !== 1) begin errors++; $display("FAIL frame_done_pulse: got %0d expected 1", fd16_cnt - fd0); end
        checks++; if (d16_buf_sel !== 1'b1) begin errors++; $display("FAIL buf_sel_toggle: got %b expected 1", d16_buf_sel); end
        send_pixels(128, 16'h0300);
        wait_words16(b + 21, 60);
        checks++; if (r16_addr[br+1] !== 24'h040000) begin errors++; $display("FAIL buf1_addr: got %h expected 040000", r16_addr[br+1]); end
        checks++; if (r16_len[br+1] !== 6'd16) begin errors++; $display("FAIL buf1_len: got %0d expected 16", r16_len[br+1]); end
    endtask

    task automatic test_seq_err();
        int b, fd0;
        do_reset();
        wr_ack = 1'b0; wr_ready = 1'b1;
        send_pixels(8, 16'h0400);
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        repeat (3) @(negedge cmos0_pclk);
        checks++; if (d16_seq_err !== 1'b0) begin errors++; $display("FAIL seq_single_vsync: got %b expected 0", d16_seq_err); end
        pixel_vsync = 1'b0;
        repeat (2) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        repeat (2) @(negedge cmos0_pclk);
        pixel_vsync = 1'b0;
        checks++; if (d16_seq_err !== 1'b1) begin errors++; $display("FAIL seq_double_vsync: got %b expected 1", d16_seq_err); end
        do_reset();
        wr_ack = 1'b0; wr_ready = 1'b1;
        b = q16_data.size(); fd0 = fd16_cnt;
        send_pixels(8, 16'h0500);
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b1;
        repeat (3) @(negedge cmos0_pclk);
        pixel_vsync = 1'b0;
        send_pixels(8, 16'h0600);
        repeat (2) @(negedge cmos0_pclk);
        checks++; if (d16_seq_err !== 1'b1) begin errors++; $display("FAIL seq_href_in_flush: got %b expected 1", d16_seq_err); end
        wr_ack = 1'b1;
        wait_frame16(fd0 + 1, 40);
        repeat (3) @(negedge cmos0_pclk);
        checks++; if (q16_data.size() - b !== 2) begin errors++; $display("FAIL seq_words_kept: got %0d expected 2", q16_data.size() - b); end
        checks++; if (q16_data[b+1] !== mk_word(16'h0600)) begin errors++; $display("FAIL seq_late_word: got %h expected %h", q16_data[b+1], mk_word(16'h0600)); end
    endtask

    task automatic test_overflow();
        int b;
        do_reset();
        wr_ack = 1'b0; wr_ready = 1'b1;
        b = q16_data.size();
        send_pixels(560, 1);
        repeat (5) @(negedge cmos0_pclk);
        checks++; if (d16_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", d16_ovf_err); end
        checks++; if (q16_data.size() - b !== 0) begin errors++; $display("FAIL ovf_no_early_data: got %0d expected 0", q16_data.size() - b); end
        wr_ack = 1'b1;
        wait_words16(b + 64, 300);
        repeat (30) @(negedge cmos0_pclk);
        checks++; if (q16_data.size() - b !== 64) begin errors++; $display("FAIL ovf_delivered: got %0d expected 64", q16_data.size() - b); end
        checks++; if (q16_data[b] !== mk_word(1)) begin errors++; $display("FAIL ovf_first: got %h expected %h", q16_data[b], mk_word(1)); end
        checks++; if (q16_data[b+63] !== mk_word(505)) begin errors++; $display("FAIL ovf_last_kept: got %h expected %h", q16_data[b+63], mk_word(505)); end
        checks++; if (d16_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", d16_ovf_err); end
    endtask

    task automatic test_reset_mid_burst();
        int b, rc0;
        logic [35:0] o16;
        do_reset();
        wr_ack = 1'b1; wr_ready = 1'b1;
        b = q16_data.size();
        send_pixels(128, 16'h0700);
        wait_words16(b + 7, 40);
        sys_rst_n = 1'b0;
        #1;
        o16 = {d16_wr_req, d16_wr_addr, d16_wr_len, d16_wr_valid, d16_wr_last, d16_frame_done, d16_buf_sel, d16_ovf_err, d16_seq_err};
        checks++; if (o16 !== 36'd0) begin errors++; $display("FAIL midburst_outs: got %h expected 0", o16); end
        checks++; if (d16_wr_data !== 128'd0) begin errors++; $display("FAIL midburst_data: got %h expected 0", d16_wr_data); end
        checks++; if (q16_data.size() - b !== 7) begin errors++; $display("FAIL midburst_words: got %0d expected 7", q16_data.size() - b); end
        repeat (2) @(negedge cmos0_pclk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge cmos0_pclk);
        rc0 = req16_cnt;
        send_pixels(120, 16'h0800);
        repeat (20) @(negedge cmos0_pclk);
        checks++; if (req16_cnt - rc0 !== 0) begin errors++; $display("FAIL midburst_no_req: got %0d req cycles expected 0", req16_cnt - rc0); end
        send_pixels(8, 16'h0878);
        wait_words16(b + 23, 60);
        checks++; if (req16_cnt - rc0 < 1) begin errors++; $display("FAIL midburst_req_after16: got %0d req cycles expected >=1", req16_cnt - rc0); end
        checks++; if (q16_data[b+7] !== mk_word(16'h0800)) begin errors++; $display("FAIL midburst_fifo_empty: got %h expected %h", q16_data[b+7], mk_word(16'h0800)); end
    endtask

    initial begin
        test_reset();
        test_reset_sync();
        test_basic_pack();
        test_line_pad();
        test_ready_toggle();
        test_flush_swap();
        test_seq_err();
        test_overflow();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/stitch_wr_packer.md
STITCH_WR_PACKER -- requirements
Module: stitch_wr_packer

Interface
REQ-001 Parameters: LINE_PIX, default 980, stitched pixels per line.
REQ-002 Parameter: BURST_WORDS, default 16, max words per write burst, 1..32.
REQ-003 Parameter: BUF_STRIDE, default 24'h040000, word-address offset of buffer 1.
REQ-004 Ports (clock and reset first): reset sys_rst_n, asynchronous, active-low; clock cmos0_pclk.
REQ-005 pixel_vsync  in  1  frame-start pulse from stitcher; rising edge = new frame.
REQ-006 pixel_href  in  1  pixel valid.
REQ-007 pixel_data  in  16  RGB565 stitched pixel.
REQ-008 wr_req  out  1  burst request; wr_addr  out  24  128-bit-word address; wr_len  out  6  words in burst.
REQ-009 wr_ack  in  1  request accepted.
REQ-010 wr_data  out  128, wr_valid  out  1, wr_last  out  1; wr_ready  in  1.
REQ-011 frame_done  out  1  one-cycle pulse; buf_sel  out  1  buffer being written; ovf_err  out  1  sticky; seq_err  out  1  sticky.

Function
REQ-012 Packing: pixels sampled when pixel_href=1; pixel k of a word (k=0..7) occupies bits [16k+15:16k].
REQ-013 Packed word pushed to internal FIFO the cycle after its 8th pixel is sampled.
REQ-014 Line end (href 1->0) with 1..7 pixels pending: pad remaining slots with 0, push the cycle after the falling edge; pixel slot counter restarts at 0.
REQ-015 FIFO: 64 x 128 bits, first-word-fall-through, simultaneous push and pop permitted.
REQ-016 FIFO full at push: word dropped, ovf_err set until reset; pop in the same cycle does not rescue the word.
REQ-017 FSM states: IDLE, REQ, DATA, SWAP.
REQ-018 IDLE->REQ when FIFO count >= BURST_WORDS (wr_len=BURST_WORDS), or when flush_pending=1 and count>0 (wr_len=min(count,BURST_WORDS)).
REQ-019 IDLE->SWAP when flush_pending=1 and FIFO count=0.
REQ-020 REQ: wr_req=1, wr_addr and wr_len stable until wr_ack=1 sampled; REQ->DATA on that cycle.
REQ-021 DATA: wr_valid=1 while burst words remain; transfer on wr_valid&wr_ready; wr_last=1 on final word; after final transfer -> IDLE, wr_addr += wr_len.
REQ-022 wr_data equals FIFO head; no word repeated or skipped regardless of wr_ready pattern.
REQ-023 pixel_vsync rising edge sets flush_pending; a second rising edge while pending sets seq_err, no other effect.
REQ-024 SWAP (one cycle): buf_sel toggles, wr_addr = new buf_sel ? BUF_STRIDE : 0, frame_done=1, flush_pending cleared, -> IDLE.
REQ-025 pixel_href=1 while flush_pending=1: pixel still packed and stored, seq_err set (stream requires vertical blanking to cover the flush).
REQ-026 wr_addr arithmetic modulo 2^24; wrap permitted, not flagged.
REQ-027 wr_ack or wr_ready outside REQ/DATA ignored.

Reset
REQ-028 sys_rst_n=0: all outputs 0, wr_addr=0, buf_sel=0, FIFO empty, slot counter 0, flush_pending 0, FSM IDLE, err flags cleared; holds mid-burst.
REQ-029 Release synchronous to cmos0_pclk via two-flop deassertion synchronizer; first pixel accepted no earlier than 2 cycles after release.

Verification
REQ-030 BURST_WORDS=2, one href of 16 pixels 0x0001..0x0010, wr_ack/wr_ready tied 1 -> wr_req addr 0 len 2; word0 = 0x0008_0007_..._0001, word1 = 0x0010_..._0009, wr_last on word1.
REQ-031 Line of 980 pixels, value = index -> 123 words; word 122 slots 0..3 = 977..980 (1-based), slots 4..7 = 0.
REQ-032 wr_ready toggles every cycle, 16-word burst -> 16 transfers in order, wr_last only on 16th accepted word, wr_valid never drops mid-burst.
REQ-033 5 words in FIFO, vsync rises -> wr_len 5 burst, then frame_done pulse, buf_sel=1, next burst wr_addr=0x040000.
REQ-034 wr_ack held 0 through 70 packed words -> 64 stored, 6 dropped, ovf_err=1; after ack, exactly 64 words delivered.
REQ-035 sys_rst_n asserted in DATA at word 7 of 16 -> same cycle all outputs 0; after release FIFO empty, no wr_req until 16 new words packed.
